// File: rtl/xsoc_trace_pkg.sv
// Package for xsoc_trace: FSM state type built on the shared encodings.
package xsoc_trace_pkg;
`include "xsoc_trace_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE    = `XSOC_ST_IDLE,
    ST_CAPTURE = `XSOC_ST_CAPTURE,
    ST_DONE    = `XSOC_ST_DONE
  } state_e;

endpackage

// File: rtl/xsoc_trace_defs.vh
// Shared definitions for the xsoc_trace bus tracer.
//   - FSM state encodings (IDLE / CAPTURE / DONE)
//   - Trace entry width: {we, addr, data}
`ifndef XSOC_TRACE_DEFS_VH
`define XSOC_TRACE_DEFS_VH

`define XSOC_ST_IDLE    2'd0
`define XSOC_ST_CAPTURE 2'd1
`define XSOC_ST_DONE    2'd2

`define XSOC_ENTRY_W(aw, dw) (1 + (aw) + (dw))

`endif

// File: rtl/xsoc_trace_ram.sv
// trace_ram: DEPTH x W storage for the tracer.
//   clk, rst_n      : clock, async active-low reset (read register only)
//   we/waddr/wdata  : synchronous write port
//   re/raddr        : read request; rdata is valid the clock after re
//   rdata           : registered read data (holds between reads)
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // Array is intentionally not reset; the owner tracks occupancy.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/xsoc_trace.sv
// xsoc_trace: external-memory bus tracer with arm/stop control and
// circular buffer readout.
//   clk, rst_n               : clock, async active-low reset
//   bus_addr/data/ce_n/we_n/oe_n : observed bus
//   arm                      : pulse; (re)starts capture, clears state
//   stop_addr                : address whose access ends capture
//   rd_en                    : pop oldest entry (DONE only)
//   rd_data/rd_valid         : popped {we, addr, data}, one clock after rd_en
//   busy/done                : registered CAPTURE / DONE state flags
//   overflow                 : an entry was overwritten during capture
//   count                    : entries held
//   cyc                      : saturating cycles since arm
`include "xsoc_trace_defs.vh"
module xsoc_trace
  import xsoc_trace_pkg::*;
#(
  parameter int AW      = 15,
  parameter int DW      = 8,
  parameter int DEPTH   = 16,
  parameter int HOLDOFF = 2,
  parameter int CW      = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [AW-1:0]                    bus_addr,
  input  logic [DW-1:0]                    bus_data,
  input  logic                             bus_ce_n,
  input  logic                             bus_we_n,
  input  logic                             bus_oe_n,
  input  logic                             arm,
  input  logic [AW-1:0]                    stop_addr,
  input  logic                             rd_en,
  output logic [`XSOC_ENTRY_W(AW,DW)-1:0]  rd_data,
  output logic                             rd_valid,
  output logic                             busy,
  output logic                             done,
  output logic                             overflow,
  output logic [$clog2(DEPTH):0]           count,
  output logic [CW-1:0]                    cyc
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = `XSOC_ENTRY_W(AW, DW);

  state_e        state_q, state_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          rdv_q, rdv_d;
  logic          busy_q, done_q;

  logic qual, cap_wr, pop, full, stop_hit;

  // Both strobes low logs as a write (we bit = !bus_we_n).
  assign qual     = !bus_ce_n && (!bus_we_n || !bus_oe_n);
  assign cap_wr   = (state_q == ST_CAPTURE) && !arm && qual;
  assign pop      = (state_q == ST_DONE) && !arm && rd_en && (cnt_q != '0);
  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign stop_hit = cap_wr && (cyc_q >= CW'(HOLDOFF)) && (bus_addr == stop_addr);

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    cyc_d   = cyc_q;
    rdv_d   = 1'b0;
    if (arm) begin
      state_d = ST_CAPTURE;
      wp_d    = '0;
      rp_d    = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      cyc_d   = '0;
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
          if (cap_wr) begin
            wp_d = wp_q + 1'b1;
            // Full buffer: drop the oldest by advancing the read side.
            if (full) begin
              rp_d  = rp_q + 1'b1;
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          if (stop_hit) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (pop) begin
            rp_d  = rp_q + 1'b1;
            cnt_d = cnt_q - 1'b1;
            rdv_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      cyc_q   <= '0;
      rdv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      cyc_q   <= cyc_d;
      rdv_q   <= rdv_d;
      busy_q  <= (state_d == ST_CAPTURE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cap_wr),
    .waddr (wp_q),
    .wdata ({!bus_we_n, bus_addr, bus_data}),
    .re    (pop),
    .raddr (rp_q),
    .rdata (rd_data)
  );

  assign rd_valid = rdv_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign count    = cnt_q;
  assign cyc      = cyc_q;

endmodule

// File: doc/xsoc_trace.md
XSOC_TRACE -- requirements
Module: xsoc_trace

Interface
REQ-001 Parameters SHALL be exactly these (name, default, meaning):
- AW, 15: bus address width.
- DW, 8: bus data width.
- DEPTH, 16: trace entries; power of 2, minimum 2.
- HOLDOFF, 2: cycles after arm before a stop match counts.
- CW, 16: cycle counter width.
REQ-002 Ports SHALL be exactly these (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- bus_addr, in, AW: external memory address.
- bus_data, in, DW: external memory data.
- bus_ce_n, in, 1: chip enable, active low.
- bus_we_n, in, 1: write enable, active low.
- bus_oe_n, in, 1: output enable, active low.
- arm, in, 1: single-cycle pulse; starts or restarts capture.
- stop_addr, in, AW: address that ends capture.
- rd_en, in, 1: pop the oldest entry.
- rd_data, out, 1+AW+DW: {we, addr, data}; we=1 marks a write.
- rd_valid, out, 1: rd_data holds a valid entry.
- busy, out, 1: in CAPTURE.
- done, out, 1: in DONE.
- overflow, out, 1: at least one entry was overwritten.
- count, out, clog2(DEPTH)+1: entries held.
- cyc, out, CW: cycles since arm; saturates at all-ones.

Function
REQ-003 A qualified cycle SHALL be bus_ce_n=0 and (bus_we_n=0 or bus_oe_n=0); if both strobes are low, the cycle SHALL be logged with we=1.
REQ-004 The FSM SHALL have three states, IDLE, CAPTURE and DONE, and SHALL enter IDLE on reset.
REQ-005 When arm=1 in any state, the next state SHALL be CAPTURE, and the following SHALL clear: write pointer, read pointer, count, overflow and cyc; rd_valid SHALL drop.
REQ-006 In CAPTURE, cyc SHALL increment by 1 every clock and saturate at 2^CW-1.
REQ-007 In CAPTURE, each qualified cycle SHALL write {we, bus_addr, bus_data} at the write pointer, and the write pointer SHALL advance modulo DEPTH.
REQ-008 In CAPTURE, a write with count=DEPTH SHALL overwrite the oldest entry, advance the read pointer, keep count at DEPTH, and set overflow; otherwise count SHALL increment.
REQ-009 Stop condition: qualified cycle AND cyc>=HOLDOFF AND bus_addr==stop_addr. The matching access SHALL be logged, and the next state SHALL be DONE.
REQ-010 The arm pulse cycle itself SHALL NOT be logged; if arm and a stop match occur in the same cycle, arm SHALL win.
REQ-011 In DONE, with rd_en=1 and count>0: the oldest entry SHALL appear on rd_data with rd_valid=1 exactly one clock later; the read pointer SHALL advance modulo DEPTH; count SHALL decrement.
REQ-012 rd_en SHALL be ignored when count=0 or when not in DONE; rd_valid SHALL be a one-cycle pulse per accepted pop.
REQ-013 Back-to-back rd_en SHALL deliver one entry per clock, oldest first, with no gaps.
REQ-014 In DONE and IDLE, bus activity SHALL be ignored, and cyc SHALL hold its value.
REQ-015 busy SHALL equal (state==CAPTURE) and done SHALL equal (state==DONE), both registered.

Reset
REQ-016 rst_n=0 SHALL immediately clear: state to IDLE; pointers, count, cyc, overflow, rd_valid and busy/done to 0; rd_data to 0.
REQ-017 Reset mid-CAPTURE or mid-readout SHALL discard all entries; buffer contents need not be cleared, since count=0 makes them unreachable.

Structure
REQ-018 State encodings and the entry-width expression SHALL reside in the shared include xsoc_trace_defs.vh.
REQ-019 Storage SHALL be one sub-module, trace_ram: DEPTH x (1+AW+DW), synchronous write, registered read, no reset on the array.
REQ-020 The block SHALL be synthesizable for on-chip debug capture and also usable as a bench monitor.

Verification
REQ-021 Arm; 3 reads at 0x0010, 0x0011, 0x0012, then a write of 0x5A to 0x0020 with stop_addr=0x0020 -> done=1, count=4; pops return {0,0010,xx}, {0,0011,xx}, {0,0012,xx}, {1,0020,5A}.
REQ-022 HOLDOFF=2, stop_addr=0x0000, access to 0x0000 at cyc=0 and again at cyc=5 -> the first access is logged without stopping; done is set after the second; count=2.
REQ-023 DEPTH=16, 20 qualified accesses to addresses 1..20 with no stop -> overflow=1, count=16; pops after a forced stop return addresses 5..20 in order.
REQ-024 arm asserted in the same cycle as a stop match -> state=CAPTURE, count=0, cyc=0.
REQ-025 In DONE with count=2, rd_en held high for 4 cycles -> exactly 2 rd_valid pulses, count=0, no pointer movement afterward.
REQ-026 rst_n pulsed low mid-readout with count=7 -> outputs are 0 during reset; after release state=IDLE, count=0, and rd_en has no effect.
